// File: rtl/slice_serial_subtractor_16bit_pkg.sv
// Shared widths, FSM state type and nibble helper for the slice-serial subtractor.
package sub_pkg;

    localparam int SLICE_W    = 4;
    localparam int NUM_SLICES = 4;
    localparam int DATA_W     = 16;
    localparam int CNT_W      = 2;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t LAST_SLICE = cnt_t'(NUM_SLICES - 1);

    function automatic logic [SLICE_W-1:0] nibble(input logic [DATA_W-1:0] word, input cnt_t idx);
        return word[idx*SLICE_W +: SLICE_W];
    endfunction

endpackage

// File: rtl/slice_serial_subtractor_16bit_borrow_slice.sv
// One 4-bit subtract slice with borrow-in/borrow-out; the borrow is the 5th result bit.
module borrow_slice_4bit
    import sub_pkg::*;
(
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    input  logic               bi_i,
    output logic [SLICE_W-1:0] d_o,
    output logic               bo_o
);

    logic [SLICE_W:0] res;

    assign res  = {1'b0, a_i} - {1'b0, b_i} - {{SLICE_W{1'b0}}, bi_i};
    assign d_o  = res[SLICE_W-1:0];
    assign bo_o = res[SLICE_W];

endmodule

// File: rtl/slice_serial_subtractor_16bit.sv
// 16-bit a - b - bin computed one nibble per clock through a single shared borrow slice.
// Define SUB_OVERFLOW_EN to add the registered signed-overflow output ovf.
module slice_serial_subtractor_16bit
    import sub_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              bin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] diff,
    output logic              bout
`ifdef SUB_OVERFLOW_EN
    ,
    output logic              ovf
`endif
);

    state_t             state_q, state_d;
    cnt_t               cnt_q;
    logic [DATA_W-1:0]  a_q, b_q, work_q, work_d, diff_q;
    logic               borrow_q, bout_q, out_valid_q;
    logic [SLICE_W-1:0] slice_d;
    logic               slice_bo;
    logic               accept;

    borrow_slice_4bit u_slice (
        .a_i  (nibble(a_q, cnt_q)),
        .b_i  (nibble(b_q, cnt_q)),
        .bi_i (borrow_q),
        .d_o  (slice_d),
        .bo_o (slice_bo)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = CALC;
            CALC:    if (cnt_q == LAST_SLICE) state_d = DONE;
            DONE:    if (out_ready) state_d = in_valid ? CALC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // in_ready is held low during reset so nothing is accepted on a reset edge.
    always_comb begin
        in_ready  = !rst && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
        out_valid = out_valid_q;
        accept    = in_valid && in_ready;
    end

    always_comb begin
        work_d = work_q;
        work_d[cnt_q*SLICE_W +: SLICE_W] = slice_d;
    end

`ifdef SUB_OVERFLOW_EN
    logic ovf_q;
    assign ovf = ovf_q;
`endif

    assign diff = diff_q;
    assign bout = bout_q;

    // Outputs only move on the edge that enters DONE; they hold through IDLE and the next CALC.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            borrow_q    <= 1'b0;
            work_q      <= '0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            if ((state_q == DONE) && out_ready) out_valid_q <= 1'b0;
            if (accept) begin
                a_q      <= a;
                b_q      <= b;
                borrow_q <= bin;
                cnt_q    <= '0;
            end else if (state_q == CALC) begin
                work_q   <= work_d;
                borrow_q <= slice_bo;
                cnt_q    <= cnt_q + cnt_t'(1);
                if (cnt_q == LAST_SLICE) begin
                    diff_q      <= work_d;
                    bout_q      <= slice_bo;
                    out_valid_q <= 1'b1;
`ifdef SUB_OVERFLOW_EN
                    ovf_q       <= (a_q[DATA_W-1] ^ b_q[DATA_W-1]) & (work_d[DATA_W-1] ^ a_q[DATA_W-1]);
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_slice_serial_subtractor_16bit.sv
// Directed self-checking bench for slice_serial_subtractor_16bit (ovf checks only with SUB_OVERFLOW_EN).
module tb_slice_serial_subtractor_16bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout;
`ifdef SUB_OVERFLOW_EN
    logic        ovf;
`endif

    int errors = 0;
    int checks = 0;

    slice_serial_subtractor_16bit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef SUB_OVERFLOW_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present an operand set before a rising edge and let it be accepted on that edge.
    task automatic applyStimulus(input string tag, input logic [15:0] ta, input logic [15:0] tb, input logic tbin);
        @(negedge clk);
        a        = ta;
        b        = tb;
        bin      = tbin;
        in_valid = 1'b1;
        #1 checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic waitResult(input string tag, input int expLat);
        int lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
    endtask

    task automatic checkResult(input string tag, input logic [15:0] ed, input logic eb, input logic eo);
        checkOutput({tag, "_diff"}, 32'(diff), 32'(ed));
        checkOutput({tag, "_bout"}, 32'(bout), 32'(eb));
`ifdef SUB_OVERFLOW_EN
        checkOutput({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
        if (eo === 1'bx) $display("[TB] note: unknown ovf expectation for %s", tag);
`endif
    endtask

    task automatic releaseResult(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        checkOutput({tag, "_released"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        bit seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_diff", 32'(diff), 32'd0);
        checkOutput("reset_bout", 32'(bout), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 checkOutput("idle_in_ready", 32'(in_ready), 32'd1);

        applyStimulus("t1", 16'h1234, 16'h0234, 1'b0);
        waitResult("t1", 4);
        checkResult("t1", 16'h1000, 1'b0, 1'b0);
        releaseResult("t1");

        applyStimulus("t2", 16'h0000, 16'h0001, 1'b0);
        waitResult("t2", 4);
        checkResult("t2", 16'hFFFF, 1'b1, 1'b0);
        releaseResult("t2");

        applyStimulus("t3", 16'h8000, 16'h0001, 1'b0);
        waitResult("t3", 4);
        checkResult("t3", 16'h7FFF, 1'b0, 1'b1);
        releaseResult("t3");

        applyStimulus("t4", 16'hFFFF, 16'hFFFF, 1'b1);
        waitResult("t4", 4);
        checkResult("t4", 16'hFFFF, 1'b1, 1'b0);
        releaseResult("t4");

        // Backpressure, then a back-to-back accept in the release cycle.
        applyStimulus("bp", 16'h0010, 16'h0001, 1'b0);
        waitResult("bp", 4);
        checkResult("bp", 16'h000F, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_hold_diff", 32'(diff), 32'h000F);
            checkOutput("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = 16'h0005;
        b         = 16'h0003;
        bin       = 1'b0;
        #1 checkOutput("b2b_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkOutput("b2b_valid_cleared", 32'(out_valid), 32'd0);
        checkOutput("b2b_diff_held", 32'(diff), 32'h000F);
        waitResult("b2b", 4);
        checkResult("b2b", 16'h0002, 1'b0, 1'b0);
        releaseResult("b2b");

        // Reset while slice 2 is being computed.
        applyStimulus("rst", 16'h1111, 16'h0001, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 checkOutput("rst_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1 if (out_valid) seen = 1'b1;
        end
        checkOutput("rst_no_valid", 32'(seen), 32'd0);
        checkOutput("rst_diff_cleared", 32'(diff), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        applyStimulus("post_rst", 16'h00FF, 16'h000F, 1'b0);
        waitResult("post_rst", 4);
        checkResult("post_rst", 16'h00F0, 1'b0, 1'b0);
        releaseResult("post_rst");

        // A new operand set offered mid-CALC must be dropped.
        applyStimulus("ign", 16'h4321, 16'h1111, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        a        = 16'hFFFF;
        b        = 16'h0000;
        bin      = 1'b1;
        #1 checkOutput("ign_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        waitResult("ign", 3);
        checkResult("ign", 16'h3210, 1'b0, 1'b0);
        releaseResult("ign");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
